// File: rtl/mult_pkg.sv
// Shared constants for the multiply-and-display sequencer: FSM encoding,
// default widths and iteration counts.
package mult_pkg;

  localparam int OP_W_DEF   = 8;
  localparam int BIN_W_DEF  = 2 * OP_W_DEF;
  localparam int DIGITS_DEF = 5;

  // One multiply iteration per multiplier bit, one BCD shift per product bit
  localparam int MULT_ITERS_DEF = OP_W_DEF;
  localparam int CONV_ITERS_DEF = BIN_W_DEF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MULT = 2'd1;
  localparam logic [1:0] ST_CONV = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/bin2bcd_iter.sv
// Iterative double-dabble converter: load a binary value, then one step per
// clock; after BIN_W steps bcd holds the packed decimal value.
module bin2bcd_iter
  import mult_pkg::*;
#(
  parameter int BIN_W  = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic [BIN_W-1:0]      bin_in,
  output logic [4*DIGITS-1:0]   bcd
);

  logic [4*DIGITS-1:0] bcd_r;
  logic [4*DIGITS-1:0] bcd_adj;
  logic [BIN_W-1:0]    bin_r;

  // Add-3 correction so each nibble carries correctly after the doubling shift
  always_comb begin
    bcd_adj = bcd_r;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_r[4*d +: 4] >= 4'd5)
        bcd_adj[4*d +: 4] = bcd_r[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_r <= '0;
      bin_r <= '0;
    end else if (load) begin
      bcd_r <= '0;
      bin_r <= bin_in;
    end else if (step) begin
      {bcd_r, bin_r} <= {bcd_adj, bin_r} << 1;
    end
  end

  assign bcd = bcd_r;

endmodule

// File: rtl/mult_display_sequencer.sv
// Signed shift-add multiply followed by BCD conversion for the display scroller.
// Optional MULT_BIN_OUT_EN adds a two's-complement bin_product output.
module mult_display_sequencer
  import mult_pkg::*;
#(
  parameter int OP_W   = OP_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [OP_W-1:0]  op_a,
  input  logic signed [OP_W-1:0]  op_b,
  output logic                    busy,
  output logic                    done,
  output logic [4*DIGITS-1:0]     bcd_product,
`ifdef MULT_BIN_OUT_EN
  output logic [2*OP_W-1:0]       bin_product,
`endif
  output logic                    sign
);

  localparam int BIN_W = 2 * OP_W;
  localparam int CNT_W = $clog2(BIN_W) + 1;
  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(OP_W - 1);
  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(BIN_W - 1);

  logic [1:0]          state;
  logic [OP_W-1:0]     mcand;
  logic [OP_W-1:0]     mplier;
  logic [BIN_W-1:0]    acc;
  logic [BIN_W-1:0]    addend;
  logic [BIN_W-1:0]    acc_next;
  logic                neg;
  logic [CNT_W-1:0]    cnt;
  logic                bcd_load;
  logic                bcd_step;
  logic [4*DIGITS-1:0] conv_bcd;

  // Magnitude as unsigned: the most negative value maps to 2^(OP_W-1) exactly
  function automatic logic [OP_W-1:0] abs_mag(input logic signed [OP_W-1:0] v);
    logic [OP_W-1:0] u;
    u = v;
    return u[OP_W-1] ? (~u + 1'b1) : u;
  endfunction

  always_comb begin
    addend   = mplier[0] ? (BIN_W'(mcand) << cnt) : '0;
    acc_next = acc + addend;
    bcd_load = (state == ST_MULT) && (cnt == MULT_LAST);
    bcd_step = (state == ST_CONV);
  end

  // The converter is loaded with acc_next so the last partial product is included
  bin2bcd_iter #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk    (clk),
    .reset  (reset),
    .load   (bcd_load),
    .step   (bcd_step),
    .bin_in (acc_next),
    .bcd    (conv_bcd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      neg         <= 1'b0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bcd_product <= '0;
      sign        <= 1'b0;
`ifdef MULT_BIN_OUT_EN
      bin_product <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mcand  <= abs_mag(op_a);
            mplier <= abs_mag(op_b);
            neg    <= op_a[OP_W-1] ^ op_b[OP_W-1];
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= ST_MULT;
          end
        end
        ST_MULT: begin
          acc    <= acc_next;
          mplier <= mplier >> 1;
          if (cnt == MULT_LAST) begin
            cnt   <= '0;
            state <= ST_CONV;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_CONV: begin
          if (cnt == CONV_LAST) begin
            cnt   <= '0;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          // Zero is never presented as negative
          bcd_product <= conv_bcd;
          sign        <= neg & (acc != '0);
`ifdef MULT_BIN_OUT_EN
          bin_product <= neg ? (~acc + 1'b1) : acc;
`endif
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_display_sequencer.sv
// Directed bench for mult_display_sequencer: vector table plus hand-written
// back-to-back and mid-operation reset sequences.
module tb_mult_display_sequencer;

  logic              clk;
  logic              reset;
  logic              start;
  logic signed [7:0] op_a;
  logic signed [7:0] op_b;
  logic              busy;
  logic              done;
  logic [19:0]       bcd_product;
  logic              sign;
`ifdef MULT_BIN_OUT_EN
  logic [15:0]       bin_product;
`endif

  int checks = 0;
  int errors = 0;

  mult_display_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op_a        (op_a),
    .op_b        (op_b),
    .busy        (busy),
    .done        (done),
    .bcd_product (bcd_product),
`ifdef MULT_BIN_OUT_EN
    .bin_product (bin_product),
`endif
    .sign        (sign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [7:0] a;
    logic signed [7:0] b;
    logic [19:0]       bcd;
    logic              sgn;
    logic [15:0]       bin;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start at edge k, then check busy/done/hold over cycles 1..25 and the result in cycle 26
  task automatic run_op(input vec_t v, input string tag);
    logic [19:0] prev_bcd;
    logic        prev_sign;
    int          win_bad;
    win_bad = 0;
    @(negedge clk);
    prev_bcd  = bcd_product;
    prev_sign = sign;
    op_a  = v.a;
    op_b  = v.b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op_a  = ~v.a;
    op_b  = ~v.b;
    for (int i = 1; i <= 25; i++) begin
      if (busy !== 1'b1 || done !== 1'b0 || bcd_product !== prev_bcd || sign !== prev_sign)
        win_bad++;
      @(posedge clk);
      #1;
    end
    check({tag, "_window"}, win_bad, 0);
    check({tag, "_done"}, {30'd0, busy, done}, 32'h1);
    check({tag, "_bcd"}, {12'd0, bcd_product}, {12'd0, v.bcd});
    check({tag, "_sign"}, {31'd0, sign}, {31'd0, v.sgn});
`ifdef MULT_BIN_OUT_EN
    check({tag, "_bin"}, {16'd0, bin_product}, {16'd0, v.bin});
`endif
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, {31'd0, done}, 32'h0);
  endtask

  initial begin
    int   n_done;
    vec_t v;

    vecs[0] = '{a: -8'sd128, b: -8'sd128, bcd: 20'h16384, sgn: 1'b0, bin: 16'h4000};
    vecs[1] = '{a:   8'sd12, b:   -8'sd5, bcd: 20'h00060, sgn: 1'b1, bin: 16'hFFC4};
    vecs[2] = '{a:    8'sd0, b:   -8'sd7, bcd: 20'h00000, sgn: 1'b0, bin: 16'h0000};
    vecs[3] = '{a:  8'sd127, b:  8'sd127, bcd: 20'h16129, sgn: 1'b0, bin: 16'h3F01};
    vecs[4] = '{a: -8'sd128, b:  8'sd127, bcd: 20'h16256, sgn: 1'b1, bin: 16'hC080};
    vecs[5] = '{a:    8'sd1, b:    8'sd1, bcd: 20'h00001, sgn: 1'b0, bin: 16'h0001};

    reset = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'h0);
    check("reset_done", {31'd0, done}, 32'h0);
    check("reset_bcd", {12'd0, bcd_product}, 32'h0);
    check("reset_sign", {31'd0, sign}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++)
      run_op(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back: second start at +10 is ignored
    @(negedge clk);
    op_a  = -8'sd1;
    op_b  = 8'sd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    n_done = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
      if (c == 10) begin
        op_a  = 8'sd3;
        op_b  = 8'sd3;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    check("b2b_done_count", n_done, 1);
    check("b2b_bcd", {12'd0, bcd_product}, 32'h00001);
    check("b2b_sign", {31'd0, sign}, 32'h1);
    check("b2b_idle", {30'd0, busy, done}, 32'h0);

    // Reset 15 cycles into -3 x 7
    @(negedge clk);
    op_a  = -8'sd3;
    op_b  = 8'sd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_bcd", {12'd0, bcd_product}, 32'h0);
    check("rst_mid_sign", {31'd0, sign}, 32'h0);
    check("rst_mid_busy", {30'd0, busy, done}, 32'h0);
    @(negedge clk);
    reset  = 1'b0;
    n_done = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) n_done++;
    end
    check("rst_mid_no_done", n_done, 0);

    v = '{a: 8'sd9, b: 8'sd9, bcd: 20'h00081, sgn: 1'b0, bin: 16'h0051};
    run_op(v, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
